cbi980_axil_bridge: RTL and testbench
=====================================

Name: cbi980_axil_bridge

Overview:
Parametrised AXI4-Lite slave front-end for CBI980-family cores. It is the successor to the fixed 32-bit AXI4-Lite wrapper.
- Accepts AW and W independently and supports byte strobes.
- Decodes a configurable address window and returns DECERR outside it.
- Forwards accepted accesses to a simple register-port handshake on the core side.
- Enforces a read timeout.
It sits between the SoC interconnect and any CBI980 core (I2S, future channels).

Parameters:
ADDR_W, 32, AXI address width
DATA_W, 32, AXI/register data width; legal values 32 or 64
BASE, 0, byte address of window start; aligned to 2^REG_AW
REG_AW, 12, window size in bytes = 2^REG_AW
TIMEOUT, 255, max cycles waiting for reg_rd_ack; 0 disables timeout

Ports:
aclk  in  1  clock
arstn  in  1  reset, asynchronous, active-low
awaddr  in  ADDR_W  write address
awprot  in  3  ignored
awvalid  in  1  write address valid
awready  out  1  write address ready
wdata  in  DATA_W  write data
wstrb  in  DATA_W/8  byte strobes
wvalid  in  1  write data valid
wready  out  1  write data ready
bresp  out  2  write response
bvalid  out  1  write response valid
bready  in  1  write response ready
araddr  in  ADDR_W  read address
arprot  in  3  ignored
arvalid  in  1  read address valid
arready  out  1  read address ready
rdata  out  DATA_W  read data
rresp  out  2  read response
rvalid  out  1  read data valid
rready  in  1  read data ready
reg_wr_en  out  1  one-cycle write strobe to core
reg_wr_addr  out  REG_AW  byte offset in window
reg_wr_data  out  DATA_W  write data
reg_wr_strb  out  DATA_W/8  byte enables
reg_wr_err  in  1  core write error, valid in the same cycle as reg_wr_en
reg_rd_req  out  1  one-cycle read request
reg_rd_addr  out  REG_AW  byte offset, held until ack or timeout
reg_rd_ack  in  1  read data valid from core
reg_rd_data  in  DATA_W  read data
reg_rd_err  in  1  core read error, qualified by reg_rd_ack

Behaviour:
- Reset:
  - arstn assertion is asynchronous; deassertion passes through a 2-flop synchroniser to an internal rst.
  - While in reset: all ready, valid, en and req outputs = 0; bresp = rresp = 0; rdata = 0; both FSMs idle.
  - Reset asserted mid-transaction aborts the transaction; no response is issued.
- Write channel, address: awready = ~aw_held & (wstate == W_IDLE). The AW handshake latches awaddr and sets aw_held.
- Write channel, data: wready = ~w_held & (wstate == W_IDLE). The W handshake latches wdata/wstrb and sets w_held. AW and W may arrive in either order or in the same cycle.
- Write FSM:
  - W_IDLE -> W_EXEC when aw_held & w_held (the registered flags).
  - W_EXEC (exactly 1 cycle):
    - Address outside [BASE, BASE+2^REG_AW): no reg_wr_en, bresp = DECERR (2'b11).
    - wstrb == 0: no reg_wr_en, bresp = OKAY.
    - Otherwise: reg_wr_en = 1, bresp = reg_wr_err ? SLVERR (2'b10) : OKAY.
    - Then go to W_RESP.
  - W_RESP: bvalid = 1, bresp held stable. On bready, clear both held flags and return to W_IDLE.
- Write latency: AW and W accepted together at cycle 0 -> reg_wr_en at cycle 2 -> bvalid at cycle 3.
- Address mapping: reg_*_addr = (addr - BASE)[REG_AW-1:0]. The low log2(DATA_W/8) bits are forced to 0.
- Read FSM:
  - R_IDLE: arready = 1. On arvalid, latch araddr. In-window -> R_REQ; out-of-window -> R_RESP with rresp = DECERR, rdata = 0.
  - R_REQ (1 cycle): reg_rd_req = 1. Clear counter; go to R_WAIT.
  - R_WAIT:
    - On reg_rd_ack: rdata = reg_rd_data, rresp = reg_rd_err ? SLVERR : OKAY, go to R_RESP.
    - Otherwise the counter increments. When it reaches TIMEOUT (and TIMEOUT != 0): rdata = 0, rresp = SLVERR, go to R_RESP.
    - Ack and timeout in the same cycle: the ack wins.
  - R_RESP: rvalid = 1, rdata/rresp stable. On rready, go to R_IDLE.
- reg_rd_ack outside R_WAIT (e.g. a late ack after timeout) is ignored.
- Read and write FSMs are fully independent. reg_wr_en and reg_rd_req may assert in the same cycle.
- Only one outstanding transaction per channel; no reordering.

Test Plan:
- AW then W 3 cycles later, addr = BASE+0x10, wdata = 0xA5A5_5A5A, wstrb = 0xF -> one reg_wr_en with reg_wr_addr = 0x010 and matching data; bvalid with bresp = 0.
- AW and W in the same cycle, wstrb = 0x3, reg_wr_err = 1 -> reg_wr_strb = 0x3; bresp = 2'b10; bready held low 5 cycles -> bvalid held, no second reg_wr_en.
- Write to addr = BASE + 2^REG_AW -> no reg_wr_en; bresp = 2'b11. Read of the same addr -> no reg_rd_req; rvalid with rresp = 2'b11, rdata = 0.
- Read addr = BASE+0x4; core acks 4 cycles after reg_rd_req with data 0x1234_5678 -> rdata = 0x1234_5678, rresp = 0, rvalid held until rready.
- TIMEOUT = 8, core never acks -> rresp = 2'b10, rdata = 0 after 8 wait cycles. A late ack before the next read is ignored; the next read returns correct data.
- arstn pulsed low while bvalid = 1 -> bvalid, awready and wready drop asynchronously. After release, a fresh write completes normally.

Source files
------------

// File: rtl/cbi980_axil_bridge.sv
// AXI4-Lite slave front-end for CBI980 cores: windowed decode, independent
// AW/W capture, one-cycle register-port strobes and a bounded read wait.
module cbi980_axil_bridge #(
    parameter int                ADDR_W  = 32,
    parameter int                DATA_W  = 32,
    parameter logic [ADDR_W-1:0] BASE    = '0,
    parameter int                REG_AW  = 12,
    parameter int                TIMEOUT = 255
) (
    input  logic                aclk,
    input  logic                arstn,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [2:0]          awprot,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wvalid,
    output logic                wready,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [2:0]          arprot,
    input  logic                arvalid,
    output logic                arready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rvalid,
    input  logic                rready,
    output logic                reg_wr_en,
    output logic [REG_AW-1:0]   reg_wr_addr,
    output logic [DATA_W-1:0]   reg_wr_data,
    output logic [DATA_W/8-1:0] reg_wr_strb,
    input  logic                reg_wr_err,
    output logic                reg_rd_req,
    output logic [REG_AW-1:0]   reg_rd_addr,
    input  logic                reg_rd_ack,
    input  logic [DATA_W-1:0]   reg_rd_data,
    input  logic                reg_rd_err
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0]  TO_CNT   = CNT_W'(TIMEOUT);
    localparam logic [REG_AW-1:0] OFF_MASK = ~REG_AW'(STRB_W - 1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE = 2'b00, W_EXEC = 2'b01, W_RESP = 2'b10} wstate_e;
    typedef enum logic [1:0] {R_IDLE = 2'b00, R_REQ = 2'b01, R_WAIT = 2'b10, R_RESP = 2'b11} rstate_e;

    // BASE is aligned to the window size, so only the upper bits need comparing.
    function automatic logic in_window(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:REG_AW] == BASE[ADDR_W-1:REG_AW];
    endfunction

    // Byte offset inside the window, rounded down to a full data word.
    function automatic logic [REG_AW-1:0] win_offset(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] diff;
        diff = a - BASE;
        return diff[REG_AW-1:0] & OFF_MASK;
    endfunction

    logic [1:0]          rst_sync_q;
    logic                rst_ok_s;
    wstate_e             wstate_q, wstate_d;
    rstate_e             rstate_q, rstate_d;
    logic                aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [1:0]          bresp_q, bresp_d, rresp_q, rresp_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc_s;
    logic                aw_hs_s, w_hs_s, ar_hs_s, reg_wr_en_s;
    logic                unused_s;

    assign unused_s = ^{awprot, arprot};

    // Reset release is synchronised; assertion reaches every flop immediately.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_ok_s = rst_sync_q[1];

    assign awready = rst_ok_s & ~aw_held_q & (wstate_q == W_IDLE);
    assign wready  = rst_ok_s & ~w_held_q & (wstate_q == W_IDLE);
    assign arready = rst_ok_s & (rstate_q == R_IDLE);
    assign aw_hs_s = awvalid & awready;
    assign w_hs_s  = wvalid & wready;
    assign ar_hs_s = arvalid & arready;
    assign cnt_inc_s = cnt_q + CNT_W'(1);

    // Write path next state: capture AW/W independently, then execute and respond.
    always_comb begin
        wstate_d    = wstate_q;
        aw_held_d   = aw_held_q;
        w_held_d    = w_held_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        bresp_d     = bresp_q;
        reg_wr_en_s = 1'b0;
        if (aw_hs_s) begin
            aw_held_d = 1'b1;
            awaddr_d  = awaddr;
        end else begin
            awaddr_d  = awaddr_q;
        end
        if (w_hs_s) begin
            w_held_d = 1'b1;
            wdata_d  = wdata;
            wstrb_d  = wstrb;
        end else begin
            wdata_d  = wdata_q;
        end
        case (wstate_q)
            W_IDLE: begin
                if (aw_held_q && w_held_q) begin
                    wstate_d = W_EXEC;
                end else begin
                    wstate_d = W_IDLE;
                end
            end
            W_EXEC: begin
                if (!in_window(awaddr_q)) begin
                    bresp_d = RESP_DECERR;
                end else if (wstrb_q == {STRB_W{1'b0}}) begin
                    bresp_d = RESP_OKAY;
                end else begin
                    reg_wr_en_s = 1'b1;
                    bresp_d     = reg_wr_err ? RESP_SLVERR : RESP_OKAY;
                end
                wstate_d = W_RESP;
            end
            W_RESP: begin
                if (bready) begin
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    wstate_d  = W_IDLE;
                end else begin
                    wstate_d  = W_RESP;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // Read path next state: decode, request, wait for ack or timeout, respond.
    always_comb begin
        rstate_d = rstate_q;
        araddr_d = araddr_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        cnt_d    = cnt_q;
        case (rstate_q)
            R_IDLE: begin
                if (ar_hs_s) begin
                    araddr_d = araddr;
                    if (in_window(araddr)) begin
                        rstate_d = R_REQ;
                    end else begin
                        rstate_d = R_RESP;
                        rresp_d  = RESP_DECERR;
                        rdata_d  = {DATA_W{1'b0}};
                    end
                end else begin
                    rstate_d = R_IDLE;
                end
            end
            R_REQ: begin
                cnt_d    = {CNT_W{1'b0}};
                rstate_d = R_WAIT;
            end
            R_WAIT: begin
                if (reg_rd_ack) begin
                    rdata_d  = reg_rd_data;
                    rresp_d  = reg_rd_err ? RESP_SLVERR : RESP_OKAY;
                    rstate_d = R_RESP;
                end else begin
                    cnt_d = cnt_inc_s;
                    if ((TIMEOUT != 0) && (cnt_inc_s == TO_CNT)) begin
                        rdata_d  = {DATA_W{1'b0}};
                        rresp_d  = RESP_SLVERR;
                        rstate_d = R_RESP;
                    end else begin
                        rstate_d = R_WAIT;
                    end
                end
            end
            R_RESP: begin
                if (rready) begin
                    rstate_d = R_IDLE;
                end else begin
                    rstate_d = R_RESP;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    // State and datapath registers for both channels.
    always_ff @(posedge aclk or negedge rst_ok_s) begin
        if (!rst_ok_s) begin
            wstate_q  <= W_IDLE;
            rstate_q  <= R_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= {ADDR_W{1'b0}};
            araddr_q  <= {ADDR_W{1'b0}};
            wdata_q   <= {DATA_W{1'b0}};
            wstrb_q   <= {STRB_W{1'b0}};
            rdata_q   <= {DATA_W{1'b0}};
            bresp_q   <= 2'b00;
            rresp_q   <= 2'b00;
            cnt_q     <= {CNT_W{1'b0}};
        end else begin
            wstate_q  <= wstate_d;
            rstate_q  <= rstate_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            araddr_q  <= araddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            bresp_q   <= bresp_d;
            rresp_q   <= rresp_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bvalid      = (wstate_q == W_RESP);
    assign bresp       = bresp_q;
    assign rvalid      = (rstate_q == R_RESP);
    assign rresp       = rresp_q;
    assign rdata       = rdata_q;
    assign reg_wr_en   = reg_wr_en_s;
    assign reg_wr_addr = win_offset(awaddr_q);
    assign reg_wr_data = wdata_q;
    assign reg_wr_strb = wstrb_q;
    assign reg_rd_req  = (rstate_q == R_REQ);
    assign reg_rd_addr = win_offset(araddr_q);

endmodule

// File: tb/tb_cbi980_axil_bridge.sv
// Scoreboard bench for cbi980_axil_bridge: directed AXI-Lite traffic,
// expected core-side and response events queued, popped by a negedge monitor.
module tb_cbi980_axil_bridge;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        aclk = 1'b0;
    logic        arstn = 1'b0;
    logic [31:0] awaddr = 32'h0, araddr = 32'h0, wdata = 32'h0;
    logic [2:0]  awprot = 3'h0, arprot = 3'h0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [3:0]  wstrb = 4'h0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        reg_wr_en, reg_rd_req;
    logic [11:0] reg_wr_addr, reg_rd_addr;
    logic [31:0] reg_wr_data;
    logic [3:0]  reg_wr_strb;
    logic        reg_wr_err = 1'b0, reg_rd_ack = 1'b0, reg_rd_err = 1'b0;
    logic [31:0] reg_rd_data = 32'h0;

    int checks = 0;
    int errors = 0;
    logic [47:0] wr_q[$];
    logic [1:0]  b_q[$];
    logic [11:0] rd_q[$];
    logic [33:0] r_q[$];
    logic [47:0] e_w;
    logic [1:0]  e_b;
    logic [11:0] e_rd;
    logic [33:0] e_r;

    cbi980_axil_bridge #(
        .ADDR_W(32), .DATA_W(32), .BASE(BASE), .REG_AW(12), .TIMEOUT(8)
    ) dut (
        .aclk(aclk), .arstn(arstn),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
        .reg_wr_strb(reg_wr_strb), .reg_wr_err(reg_wr_err),
        .reg_rd_req(reg_rd_req), .reg_rd_addr(reg_rd_addr), .reg_rd_ack(reg_rd_ack),
        .reg_rd_data(reg_rd_data), .reg_rd_err(reg_rd_err)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every DUT-presented event pops its queued expectation.
    always @(negedge aclk) begin
        if (reg_wr_en === 1'b1) begin
            if (wr_q.size() == 0) check("unexpected_reg_wr_en", 64'd1, 64'd0);
            else begin
                e_w = wr_q.pop_front();
                check("reg_wr", 64'({reg_wr_addr, reg_wr_data, reg_wr_strb}), 64'(e_w));
            end
        end
        if (reg_rd_req === 1'b1) begin
            if (rd_q.size() == 0) check("unexpected_reg_rd_req", 64'd1, 64'd0);
            else begin
                e_rd = rd_q.pop_front();
                check("reg_rd_addr", 64'(reg_rd_addr), 64'(e_rd));
            end
        end
        if (bvalid === 1'b1 && bready === 1'b1) begin
            if (b_q.size() == 0) check("unexpected_bresp", 64'd1, 64'd0);
            else begin
                e_b = b_q.pop_front();
                check("bresp", 64'(bresp), 64'(e_b));
            end
        end
        if (rvalid === 1'b1 && rready === 1'b1) begin
            if (r_q.size() == 0) check("unexpected_rresp", 64'd1, 64'd0);
            else begin
                e_r = r_q.pop_front();
                check("rdata_rresp", 64'({rdata, rresp}), 64'(e_r));
            end
        end
    end

    function automatic logic sig_sel(input int sel);
        case (sel)
            0: return awready;
            1: return wready;
            2: return arready;
            3: return bvalid;
            4: return rvalid;
            5: return reg_rd_req;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input string name, input int sel);
        for (int n = 0; n < 100; n++) begin
            @(negedge aclk);
            if (sig_sel(sel) === 1'b1) return;
        end
        check({"timeout_", name}, 64'd0, 64'd1);
    endtask

    task automatic send_aw(input logic [31:0] a);
        awaddr = a; awvalid = 1'b1;
        wait_for("awready", 0);
        @(posedge aclk); #1 awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        wdata = d; wstrb = s; wvalid = 1'b1;
        wait_for("wready", 1);
        @(posedge aclk); #1 wvalid = 1'b0;
    endtask

    task automatic send_aw_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        wait_for("awready", 0);
        check("wready_same_cycle", 64'(wready), 64'd1);
        @(posedge aclk); #1 awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] a);
        araddr = a; arvalid = 1'b1;
        wait_for("arready", 2);
        @(posedge aclk); #1 arvalid = 1'b0;
    endtask

    task automatic take_b();
        wait_for("bvalid", 3);
        @(posedge aclk); #1 bready = 1'b1;
        @(posedge aclk); #1 bready = 1'b0;
    endtask

    task automatic take_r(input int hold);
        wait_for("rvalid", 4);
        for (int i = 0; i < hold; i++) begin
            @(negedge aclk);
            check("rvalid_held", 64'(rvalid), 64'd1);
        end
        @(posedge aclk); #1 rready = 1'b1;
        @(posedge aclk); #1 rready = 1'b0;
    endtask

    task automatic core_ack(input int dly, input logic [31:0] d, input logic e);
        wait_for("reg_rd_req", 5);
        repeat (dly) @(posedge aclk);
        #1 reg_rd_ack = 1'b1; reg_rd_data = d; reg_rd_err = e;
        @(posedge aclk); #1 reg_rd_ack = 1'b0; reg_rd_err = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_awready", 64'(awready), 64'd0);
        check("rst_wready", 64'(wready), 64'd0);
        check("rst_arready", 64'(arready), 64'd0);
        check("rst_bvalid", 64'(bvalid), 64'd0);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_reg_wr_en", 64'(reg_wr_en), 64'd0);
        check("rst_reg_rd_req", 64'(reg_rd_req), 64'd0);
        check("rst_resps", 64'({bresp, rresp}), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        arstn = 1'b1;
        repeat (4) @(posedge aclk);
        #1;
        check("idle_awready", 64'(awready), 64'd1);
        check("idle_arready", 64'(arready), 64'd1);

        // AW first, W three cycles later
        wr_q.push_back({12'h010, 32'hA5A5_5A5A, 4'hF}); b_q.push_back(2'b00);
        send_aw(BASE + 32'h10);
        @(negedge aclk);
        check("awready_low_when_held", 64'(awready), 64'd0);
        check("wready_while_aw_held", 64'(wready), 64'd1);
        @(posedge aclk); #1;
        @(posedge aclk); #1;
        send_w(32'hA5A5_5A5A, 4'hF);
        take_b();

        // AW+W same cycle, core error, bready stalled
        reg_wr_err = 1'b1;
        wr_q.push_back({12'h020, 32'h1111_2222, 4'h3}); b_q.push_back(2'b10);
        send_aw_w(BASE + 32'h20, 32'h1111_2222, 4'h3);
        n = 0;
        do begin @(negedge aclk); n++; end while (reg_wr_en !== 1'b1 && n < 20);
        check("wr_en_latency", 64'(n), 64'd2);
        @(negedge aclk);
        check("bvalid_latency", 64'(bvalid), 64'd1);
        reg_wr_err = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            check("bvalid_held", 64'({bvalid, bresp}), 64'({1'b1, 2'b10}));
        end
        @(posedge aclk); #1 bready = 1'b1;
        @(posedge aclk); #1 bready = 1'b0;

        // window boundaries, empty strobe, unaligned address, W before AW
        b_q.push_back(2'b11);
        send_aw_w(BASE + 32'h1000, 32'hFFFF_FFFF, 4'hF);
        take_b();
        b_q.push_back(2'b11);
        send_aw_w(BASE - 32'h4, 32'hFFFF_FFFF, 4'hF);
        take_b();
        b_q.push_back(2'b00);
        send_aw_w(BASE + 32'h40, 32'h0000_0005, 4'h0);
        take_b();
        wr_q.push_back({12'h010, 32'h0BAD_F00D, 4'h8}); b_q.push_back(2'b00);
        send_aw_w(BASE + 32'h13, 32'h0BAD_F00D, 4'h8);
        take_b();
        wr_q.push_back({12'h050, 32'h5050_AAAA, 4'hC}); b_q.push_back(2'b00);
        send_w(32'h5050_AAAA, 4'hC);
        send_aw(BASE + 32'h50);
        take_b();

        // reads: decode error, acked read, last word with core error
        r_q.push_back({32'h0, 2'b11});
        send_ar(BASE + 32'h1000);
        take_r(0);
        rd_q.push_back(12'h004); r_q.push_back({32'h1234_5678, 2'b00});
        send_ar(BASE + 32'h4);
        core_ack(4, 32'h1234_5678, 1'b0);
        take_r(3);
        rd_q.push_back(12'hFFC); r_q.push_back({32'h89AB_CDEF, 2'b10});
        send_ar(BASE + 32'hFFF);
        core_ack(1, 32'h89AB_CDEF, 1'b1);
        take_r(0);

        // timeout, late ack ignored, following read intact
        rd_q.push_back(12'h008); r_q.push_back({32'h0, 2'b10});
        send_ar(BASE + 32'h8);
        wait_for("reg_rd_req", 5);
        n = 0;
        do begin @(negedge aclk); n++; end while (rvalid !== 1'b1 && n < 40);
        check("timeout_latency", 64'(n), 64'd9);
        take_r(0);
        reg_rd_ack = 1'b1; reg_rd_data = 32'hDEAD_BEEF; reg_rd_err = 1'b1;
        @(posedge aclk); #1 reg_rd_ack = 1'b0; reg_rd_err = 1'b0;
        rd_q.push_back(12'h00C); r_q.push_back({32'hCAFE_F00D, 2'b00});
        send_ar(BASE + 32'hC);
        core_ack(2, 32'hCAFE_F00D, 1'b0);
        take_r(0);

        // reset while bvalid is up, then a fresh write
        wr_q.push_back({12'h030, 32'h3030_3030, 4'hF}); b_q.push_back(2'b00);
        send_aw_w(BASE + 32'h30, 32'h3030_3030, 4'hF);
        wait_for("bvalid", 3);
        #2 arstn = 1'b0;
        #1;
        check("async_rst_bvalid", 64'(bvalid), 64'd0);
        check("async_rst_awready", 64'(awready), 64'd0);
        check("async_rst_wready", 64'(wready), 64'd0);
        b_q.delete();
        repeat (3) @(posedge aclk);
        #1 arstn = 1'b1;
        repeat (4) @(posedge aclk);
        #1;
        wr_q.push_back({12'h034, 32'h3434_3434, 4'hF}); b_q.push_back(2'b00);
        send_aw_w(BASE + 32'h34, 32'h3434_3434, 4'hF);
        take_b();

        repeat (5) @(posedge aclk);
        check("wr_q_drained", 64'(wr_q.size()), 64'd0);
        check("b_q_drained", 64'(b_q.size()), 64'd0);
        check("rd_q_drained", 64'(rd_q.size()), 64'd0);
        check("r_q_drained", 64'(r_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
